// File: rtl/icacop_responder.sv
// rtl/icacop_responder.sv - I-cache CACOP responder: tag-array index/hit invalidate with one response per request
//
// Ports:
//   clk, a_rst_n           clock, asynchronous active-low reset
//   flush_i                synchronous pipeline flush; drops the in-flight request
//   req_*                  CACOP request from the memory-pipeline initiator (valid/ready)
//   rsp_*                  response to initiator stage 2; rsp_valid_o doubles as I-cache busy
//   trans_*                MMU translation request/result used by hit-invalidate (mode 2)
//   icache_idle_i          no refill in flight; requests are only accepted while high
//   tag_*                  I-cache tag RAM port (1-cycle read latency, {tag, valid} entries)
//   stat_ops_o/stat_hits_o response and mode-2 hit counters, only when ICACOP_STAT_EN is defined
module icacop_responder #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_BYTES = 16,
  parameter int PADDR_W    = 32,
  parameter int ROB_IDX_W  = 6,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_BYTES),
  localparam int TAG_W     = PADDR_W - IDX_W - OFF_W
) (
  input  logic                        clk,
  input  logic                        a_rst_n,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [31:0]                 req_vaddr_i,
  input  logic [ROB_IDX_W-1:0]        req_rob_idx_i,
  input  logic [1:0]                  req_mode_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [ROB_IDX_W-1:0]        rsp_rob_idx_o,
  output logic [31:0]                 rsp_vaddr_o,
  output logic                        rsp_excp_o,
  output logic [5:0]                  rsp_ecode_o,
  output logic                        trans_valid_o,
  output logic [31:0]                 trans_vaddr_o,
  input  logic                        trans_ready_i,
  input  logic                        trans_rsp_valid_i,
  input  logic [PADDR_W-1:0]          trans_paddr_i,
  input  logic                        trans_excp_i,
  input  logic [5:0]                  trans_ecode_i,
  input  logic                        icache_idle_i,
  output logic                        tag_en_o,
  output logic                        tag_we_o,
  output logic [WAYS-1:0]             tag_way_o,
  output logic [IDX_W-1:0]            tag_idx_o,
  output logic [TAG_W:0]              tag_wdata_o,
  input  logic [WAYS*(TAG_W+1)-1:0]   tag_rdata_i
`ifdef ICACOP_STAT_EN
  ,
  output logic [31:0]                 stat_ops_o,
  output logic [31:0]                 stat_hits_o
`endif
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int ENT_W = TAG_W + 1;

  typedef enum logic [2:0] {IDLE, TRANS, WAIT_TR, READ, CMP, WRITE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   run_q;
  logic [31:0]            vaddr_q;
  logic [ROB_IDX_W-1:0]   rob_q;
  logic [IDX_W-1:0]       idx_q;
  logic [WAYS-1:0]        way_q;
  logic [TAG_W-1:0]       tag_q;
  logic                   excp_q;
  logic [5:0]             ecode_q;

  logic                   accept;
  logic                   tr_take;
  logic                   hit_any;
  logic [WAYS-1:0]        hit_oh;
  logic [ENT_W-1:0]       entry;
  logic                   unused_paddr_off;

  // Line-offset bits of the physical address play no part in tag or index.
  assign unused_paddr_off = ^trans_paddr_i[OFF_W-1:0];

  // Tag compare against the read data of the READ cycle; lowest matching way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_oh  = '0;
    entry   = '0;
    for (int w = 0; w < WAYS; w++) begin
      entry = tag_rdata_i[w*ENT_W +: ENT_W];
      if (!hit_any && entry[0] && (entry[ENT_W-1:1] == tag_q)) begin
        hit_any   = 1'b1;
        hit_oh[w] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    tr_take       = 1'b0;
    trans_valid_o = 1'b0;
    tag_en_o      = 1'b0;
    tag_we_o      = 1'b0;
    rsp_valid_o   = 1'b0;
    // run_q keeps ready low in the reset cycle so every output starts at 0.
    req_ready_o   = (state_q == IDLE) && icache_idle_i && !flush_i && run_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          accept = 1'b1;
          case (req_mode_i)
            2'd0, 2'd1: state_d = WRITE;
            2'd2:       state_d = TRANS;
            default:    state_d = RESP;
          endcase
        end
      end
      TRANS: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) begin
          if (trans_rsp_valid_i) begin
            tr_take = 1'b1;
            state_d = trans_excp_i ? RESP : READ;
          end else begin
            state_d = WAIT_TR;
          end
        end
      end
      WAIT_TR: begin
        if (trans_rsp_valid_i) begin
          tr_take = 1'b1;
          state_d = trans_excp_i ? RESP : READ;
        end
      end
      READ: begin
        tag_en_o = 1'b1;
        state_d  = CMP;
      end
      CMP: begin
        state_d = hit_any ? WRITE : RESP;
      end
      WRITE: begin
        tag_en_o = 1'b1;
        tag_we_o = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d       = IDLE;
      trans_valid_o = 1'b0;
      tag_we_o      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      vaddr_q <= '0;
      rob_q   <= '0;
      idx_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      excp_q  <= 1'b0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (accept) begin
        vaddr_q <= req_vaddr_i;
        rob_q   <= req_rob_idx_i;
        idx_q   <= req_vaddr_i[OFF_W +: IDX_W];
        way_q   <= WAYS'(1) << req_vaddr_i[WAY_W-1:0];
        excp_q  <= 1'b0;
        ecode_q <= '0;
      end
      if (tr_take) begin
        if (trans_excp_i) begin
          excp_q  <= 1'b1;
          ecode_q <= trans_ecode_i;
        end else begin
          tag_q <= trans_paddr_i[PADDR_W-1 -: TAG_W];
          idx_q <= trans_paddr_i[OFF_W +: IDX_W];
        end
      end
      if (state_q == CMP && hit_any) way_q <= hit_oh;
    end
  end

  assign rsp_rob_idx_o = rob_q;
  assign rsp_vaddr_o   = vaddr_q;
  assign rsp_excp_o    = excp_q;
  assign rsp_ecode_o   = ecode_q;
  assign trans_vaddr_o = vaddr_q;
  assign tag_way_o     = way_q;
  assign tag_idx_o     = idx_q;
  assign tag_wdata_o   = '0;

`ifdef ICACOP_STAT_EN
  logic [31:0] stat_ops_q, stat_hits_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      stat_ops_q  <= '0;
      stat_hits_q <= '0;
    end else begin
      if (rsp_valid_o && rsp_ready_i) stat_ops_q  <= stat_ops_q + 32'd1;
      if (state_q == CMP && hit_any)  stat_hits_q <= stat_hits_q + 32'd1;
    end
  end

  assign stat_ops_o  = stat_ops_q;
  assign stat_hits_o = stat_hits_q;
`endif

endmodule

// File: tb/tb_icacop_responder.sv
// tb/tb_icacop_responder.sv - scoreboard testbench for icacop_responder
module tb_icacop_responder;

  logic        clk = 1'b0;
  logic        a_rst_n;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic [5:0]  req_rob_idx_i;
  logic [1:0]  req_mode_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [5:0]  rsp_rob_idx_o;
  logic [31:0] rsp_vaddr_o;
  logic        rsp_excp_o;
  logic [5:0]  rsp_ecode_o;
  logic        trans_valid_o;
  logic [31:0] trans_vaddr_o;
  logic        trans_ready_i;
  logic        trans_rsp_valid_i;
  logic [31:0] trans_paddr_i;
  logic        trans_excp_i;
  logic [5:0]  trans_ecode_i;
  logic        icache_idle_i;
  logic        tag_en_o;
  logic        tag_we_o;
  logic [1:0]  tag_way_o;
  logic [7:0]  tag_idx_o;
  logic [20:0] tag_wdata_o;
  logic [41:0] tag_rdata_i;
`ifdef ICACOP_STAT_EN
  logic [31:0] stat_ops_o, stat_hits_o;
`endif

  always #5 clk = ~clk;

  icacop_responder dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
    .req_rob_idx_i(req_rob_idx_i), .req_mode_i(req_mode_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rob_idx_o(rsp_rob_idx_o),
    .rsp_vaddr_o(rsp_vaddr_o), .rsp_excp_o(rsp_excp_o), .rsp_ecode_o(rsp_ecode_o),
    .trans_valid_o(trans_valid_o), .trans_vaddr_o(trans_vaddr_o), .trans_ready_i(trans_ready_i),
    .trans_rsp_valid_i(trans_rsp_valid_i), .trans_paddr_i(trans_paddr_i),
    .trans_excp_i(trans_excp_i), .trans_ecode_i(trans_ecode_i),
    .icache_idle_i(icache_idle_i), .tag_en_o(tag_en_o), .tag_we_o(tag_we_o),
    .tag_way_o(tag_way_o), .tag_idx_o(tag_idx_o), .tag_wdata_o(tag_wdata_o),
    .tag_rdata_i(tag_rdata_i)
`ifdef ICACOP_STAT_EN
    , .stat_ops_o(stat_ops_o), .stat_hits_o(stat_hits_o)
`endif
  );

  typedef struct packed {
    logic [5:0]  rob;
    logic [31:0] va;
    logic        excp;
    logic [5:0]  ecode;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [7:0]  rd_q[$];
  logic [9:0]  wr_q[$];
  logic [41:0] rdata_set;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Tag RAM model: 1-cycle read latency
  always @(posedge clk) if (tag_en_o && !tag_we_o) tag_rdata_i <= rdata_set;

  // Monitor: responses, tag reads and tag writes are popped from the scoreboard queues
  rsp_t       m_rsp;
  logic [9:0] m_wr;
  always @(negedge clk) begin
    if (a_rst_n) begin
      if (rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          m_rsp = rsp_q.pop_front();
          chk("rsp_rob", rsp_rob_idx_o, m_rsp.rob);
          chk("rsp_vaddr", rsp_vaddr_o, m_rsp.va);
          chk("rsp_excp", rsp_excp_o, m_rsp.excp);
          chk("rsp_ecode", rsp_ecode_o, m_rsp.ecode);
        end
      end
      if (tag_en_o) begin
        if (tag_we_o) begin
          if (wr_q.size() == 0) chk("unexpected_tag_write", 1, 0);
          else begin
            m_wr = wr_q.pop_front();
            chk("wr_idx", tag_idx_o, m_wr[9:2]);
            chk("wr_way", tag_way_o, m_wr[1:0]);
            chk("wr_wdata", tag_wdata_o, 0);
          end
        end else begin
          if (rd_q.size() == 0) chk("unexpected_tag_read", 1, 0);
          else chk("rd_idx", tag_idx_o, rd_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [31:0] va, input logic [5:0] rob);
    req_valid_i = 1'b1; req_mode_i = m; req_vaddr_i = va; req_rob_idx_i = rob;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    chk("accept_ready", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_trans(input logic [31:0] va);
    for (int i = 0; i < 50; i++) begin
      if (trans_valid_o) break;
      @(negedge clk);
    end
    chk("trans_valid", trans_valid_o, 1);
    chk("trans_vaddr", trans_vaddr_o, va);
  endtask

  task automatic wait_done;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid_o && rsp_ready_i) break;
    end
    chk("rsp_handoff", rsp_valid_o && rsp_ready_i, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst_n = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_vaddr_i = '0;
    req_rob_idx_i = '0; req_mode_i = '0; rsp_ready_i = 1'b1; trans_ready_i = 1'b0;
    trans_rsp_valid_i = 1'b0; trans_paddr_i = '0; trans_excp_i = 1'b0; trans_ecode_i = '0;
    icache_idle_i = 1'b1; tag_rdata_i = '0; rdata_set = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {req_ready_o, rsp_valid_o, rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o,
                          rsp_ecode_o, trans_valid_o, trans_vaddr_o, tag_en_o, tag_we_o,
                          tag_way_o, tag_idx_o}, 0);
    @(posedge clk); #1 a_rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 1 index invalidate: write at T+1, response at T+2
    wr_q.push_back({8'h23, 2'b10});
    rsp_q.push_back('{rob: 6'd5, va: 32'h0000_1231, excp: 1'b0, ecode: 6'd0});
    send(2'd1, 32'h0000_1231, 6'd5);
    @(negedge clk); chk("m1_we_at_T+1", tag_we_o, 1);
    @(negedge clk); chk("m1_rsp_at_T+2", rsp_valid_o, 1);
    @(posedge clk); #1;

    // Mode 0 store tag at the top index, way 0
    wr_q.push_back({8'hFF, 2'b01});
    rsp_q.push_back('{rob: 6'd6, va: 32'h0000_0FF0, excp: 1'b0, ecode: 6'd0});
    send(2'd0, 32'h0000_0FF0, 6'd6);
    wait_done();

    // Mode 2 hit, both ways match: lowest way wins; ready and result in same cycle
    rdata_set = {20'h80002, 1'b1, 20'h80002, 1'b1};
    rd_q.push_back(8'h04);
    wr_q.push_back({8'h04, 2'b01});
    rsp_q.push_back('{rob: 6'd9, va: 32'h1234_5040, excp: 1'b0, ecode: 6'd0});
    send(2'd2, 32'h1234_5040, 6'd9);
    wait_trans(32'h1234_5040);
    trans_ready_i = 1'b1; trans_rsp_valid_i = 1'b1; trans_paddr_i = 32'h8000_2040;
    @(posedge clk); #1 trans_ready_i = 1'b0; trans_rsp_valid_i = 1'b0;
    wait_done();

    // Mode 2 miss: way0 tag differs, way1 tag matches but invalid; response 3 cycles after result
    rdata_set = {20'h80002, 1'b0, 20'h80003, 1'b1};
    rd_q.push_back(8'h04);
    rsp_q.push_back('{rob: 6'd10, va: 32'h0000_0040, excp: 1'b0, ecode: 6'd0});
    send(2'd2, 32'h0000_0040, 6'd10);
    wait_trans(32'h0000_0040);
    trans_ready_i = 1'b1;
    @(posedge clk); #1 trans_ready_i = 1'b0;
    @(posedge clk); #1 trans_rsp_valid_i = 1'b1; trans_paddr_i = 32'h8000_2040;
    @(posedge clk); #1 trans_rsp_valid_i = 1'b0;
    @(negedge clk); chk("miss_rsp_r+1", rsp_valid_o, 0);
    @(negedge clk); chk("miss_rsp_r+2", rsp_valid_o, 0);
    @(negedge clk); chk("miss_rsp_r+3", rsp_valid_o, 1);
    @(posedge clk); #1;

    // Mode 2 translation fault, response held 5 cycles
    rsp_ready_i = 1'b0;
    rsp_q.push_back('{rob: 6'd17, va: 32'hABCD_0010, excp: 1'b1, ecode: 6'h01});
    send(2'd2, 32'hABCD_0010, 6'd17);
    wait_trans(32'hABCD_0010);
    trans_ready_i = 1'b1; trans_rsp_valid_i = 1'b1; trans_excp_i = 1'b1;
    trans_ecode_i = 6'h01; trans_paddr_i = 32'h0000_0000;
    @(posedge clk); #1 trans_ready_i = 1'b0; trans_rsp_valid_i = 1'b0; trans_excp_i = 1'b0;
    trans_ecode_i = 6'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_fields", {rsp_rob_idx_o, rsp_vaddr_o, rsp_excp_o, rsp_ecode_o},
          {6'd17, 32'hABCD_0010, 1'b1, 6'h01});
    end
    @(posedge clk); #1 rsp_ready_i = 1'b1;
    wait_done();

    // Flush during WAIT_TR: no response, late translation result ignored
    send(2'd2, 32'h5555_0030, 6'd20);
    wait_trans(32'h5555_0030);
    trans_ready_i = 1'b1;
    @(posedge clk); #1 trans_ready_i = 1'b0; flush_i = 1'b1;
    @(negedge clk); chk("flush_trans_valid", trans_valid_o, 0);
    @(posedge clk); #1 flush_i = 1'b0; trans_rsp_valid_i = 1'b1; trans_paddr_i = 32'h8000_2030;
    @(posedge clk); #1 trans_rsp_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("flush_no_rsp", rsp_valid_o, 0);
    end
    chk("flush_back_idle", req_ready_o, 1);
    @(posedge clk); #1;

    // icache busy blocks acceptance; accepted in the cycle idle returns (mode 3 reserved)
    icache_idle_i = 1'b0;
    req_valid_i = 1'b1; req_mode_i = 2'd3; req_vaddr_i = 32'h0000_0777; req_rob_idx_i = 6'd33;
    rsp_q.push_back('{rob: 6'd33, va: 32'h0000_0777, excp: 1'b0, ecode: 6'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("busy_req_ready", req_ready_o, 0);
    end
    @(posedge clk); #1 icache_idle_i = 1'b1;
    @(negedge clk); chk("idle_req_ready", req_ready_o, 1);
    @(posedge clk); #1 req_valid_i = 1'b0;
    wait_done();

    @(posedge clk); #1;
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
`ifdef ICACOP_STAT_EN
    chk("stat_ops", stat_ops_o, 6);
    chk("stat_hits", stat_hits_o, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
